// File: rtl/alien_fleet.sv
// Space-Invaders alien formation: ROWS x COLS alive mask that marches, drops at the edges,
// speeds up as aliens die, and reports per-pixel membership for the colour mapper.
module alien_fleet #(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 8,
  parameter int unsigned SPACE_XL2 = 5,
  parameter int unsigned SPACE_YL2 = 4,
  parameter int unsigned ALIEN_W   = 24,
  parameter int unsigned ALIEN_H   = 12,
  parameter int unsigned X_START   = 64,
  parameter int unsigned Y_START   = 40,
  parameter int unsigned X_MIN     = 0,
  parameter int unsigned X_MAX     = 639,
  parameter int unsigned Y_LAND    = 400,
  parameter int unsigned STEP_X    = 4,
  parameter int unsigned STEP_Y    = 8,
  parameter int unsigned SPD_SHIFT = 2,
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned NW = $clog2(ROWS * COLS + 1)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          frame_clk,
  input  logic          restart,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          hit_valid,
  input  logic [RW-1:0] hit_row,
  input  logic [CW-1:0] hit_col,
  output logic          hit_ack,
  output logic          is_alien,
  output logic [RW-1:0] alien_row,
  output logic [CW-1:0] alien_col,
  output logic          anim_frame,
  output logic [9:0]    fleet_x,
  output logic [9:0]    fleet_y,
  output logic [NW-1:0] alive_count,
  output logic          fleet_cleared,
  output logic          fleet_landed
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned XW = 11 - SPACE_XL2;
  localparam int unsigned YW = 11 - SPACE_YL2;

  typedef enum logic [1:0] {StMarch, StDrop, StHalt} state_e;

  state_e        state_q;
  logic [N-1:0]  alive_q;
  logic [9:0]    fleet_x_q, fleet_y_q;
  logic          dir_left_q, anim_q, hit_ack_q, landed_q;
  logic [NW-1:0] count_q, frame_cnt_q, count_next, reload;
  logic [2:0]    sync_q;
  logic          tick;

  // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the edge-detect history
  assign tick   = sync_q[1] & ~sync_q[2];
  assign reload = (count_q >> SPD_SHIFT) + NW'(1);

  logic [COLS-1:0] col_occ;
  logic [ROWS-1:0] row_occ;
  logic [CW-1:0]   lcol, rcol;
  logic [RW-1:0]   brow;

  always_comb begin
    col_occ    = '0;
    row_occ    = '0;
    count_next = '0;
    lcol       = '0;
    rcol       = '0;
    brow       = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (alive_q[r*COLS+c]) begin
          col_occ[c] = 1'b1;
          row_occ[r] = 1'b1;
        end
      end
    end
    for (int unsigned i = 0; i < N; i++) count_next = count_next + NW'(alive_q[i]);
    for (int c = int'(COLS) - 1; c >= 0; c--) if (col_occ[c]) lcol = CW'(c);
    for (int unsigned c = 0; c < COLS; c++) if (col_occ[c]) rcol = CW'(c);
    for (int unsigned r = 0; r < ROWS; r++) if (row_occ[r]) brow = RW'(r);
  end

  logic [11:0] right_edge, left_edge, bottom_edge;
  logic        past_right, past_left, landed_now;

  assign right_edge  = 12'(fleet_x_q) + (12'(rcol) << SPACE_XL2) + 12'(ALIEN_W + STEP_X - 1);
  assign left_edge   = 12'(fleet_x_q) + (12'(lcol) << SPACE_XL2);
  assign bottom_edge = 12'(fleet_y_q) + (12'(brow) << SPACE_YL2) + 12'(ALIEN_H - 1);
  assign past_right  = right_edge > 12'(X_MAX);
  assign past_left   = left_edge < 12'(X_MIN + STEP_X);
  // An empty fleet has no bottom pixel, so it can never land
  assign landed_now  = (|alive_q) && (bottom_edge >= 12'(Y_LAND));

  logic [IW-1:0] hit_idx;
  logic          hit_ok;

  always_comb begin
    hit_idx = IW'(int'(hit_row) * int'(COLS) + int'(hit_col));
    hit_ok  = 1'b0;
    if (hit_valid && int'(hit_row) < int'(ROWS) && int'(hit_col) < int'(COLS)
        && !(state_q == StHalt && fleet_cleared)) begin
      hit_ok = alive_q[hit_idx];
    end
  end

  logic signed [10:0] rx, ry;
  logic [XW-1:0]      col_p;
  logic [YW-1:0]      row_p;
  logic [IW-1:0]      pix_idx;
  logic               pix_hit;

  always_comb begin
    rx      = $signed({1'b0, DrawX}) - $signed({1'b0, fleet_x_q});
    ry      = $signed({1'b0, DrawY}) - $signed({1'b0, fleet_y_q});
    col_p   = rx[10:SPACE_XL2];
    row_p   = ry[10:SPACE_YL2];
    pix_idx = IW'(int'(row_p) * int'(COLS) + int'(col_p));
    pix_hit = 1'b0;
    if (!rx[10] && !ry[10] && int'(col_p) < int'(COLS) && int'(row_p) < int'(ROWS)
        && int'(rx[SPACE_XL2-1:0]) < int'(ALIEN_W)
        && int'(ry[SPACE_YL2-1:0]) < int'(ALIEN_H)) begin
      pix_hit = alive_q[pix_idx];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], frame_clk};
    hit_ack_q <= 1'b0;
    if (!Reset_n || restart) begin
      alive_q     <= '1;
      count_q     <= NW'(N);
      frame_cnt_q <= NW'((N >> SPD_SHIFT) + 1);
      fleet_x_q   <= 10'(X_START);
      fleet_y_q   <= 10'(Y_START);
      dir_left_q  <= 1'b0;
      anim_q      <= 1'b0;
      landed_q    <= 1'b0;
      state_q     <= StMarch;
    end else begin
      count_q <= count_next;
      if (hit_ok) begin
        alive_q[hit_idx] <= 1'b0;
        hit_ack_q        <= 1'b1;
      end
      if (landed_now) landed_q <= 1'b1;
      case (state_q)
        StMarch: begin
          if (landed_now || fleet_cleared) begin
            state_q <= StHalt;
          end else if (tick) begin
            if (frame_cnt_q == NW'(1)) begin
              anim_q      <= ~anim_q;
              frame_cnt_q <= reload;
              if (!dir_left_q) begin
                if (past_right) state_q <= StDrop;
                else            fleet_x_q <= fleet_x_q + 10'(STEP_X);
              end else begin
                if (past_left) state_q <= StDrop;
                else           fleet_x_q <= fleet_x_q - 10'(STEP_X);
              end
            end else begin
              frame_cnt_q <= frame_cnt_q - NW'(1);
            end
          end
        end
        StDrop: begin
          fleet_y_q  <= fleet_y_q + 10'(STEP_Y);
          dir_left_q <= ~dir_left_q;
          state_q    <= StMarch;
        end
        default: ;
      endcase
    end
  end

  assign hit_ack       = hit_ack_q;
  assign is_alien      = pix_hit;
  assign alien_row     = pix_hit ? RW'(row_p) : '0;
  assign alien_col     = pix_hit ? CW'(col_p) : '0;
  assign anim_frame    = anim_q;
  assign fleet_x       = fleet_x_q;
  assign fleet_y       = fleet_y_q;
  assign alive_count   = count_q;
  assign fleet_cleared = (count_q == '0);
  assign fleet_landed  = landed_q;

endmodule

// File: tb/tb_alien_fleet.sv
// Directed bench for alien_fleet: default-size fleet (a) plus a 1x1 fleet with tight bounds (b)
// for the drop/landing and reset-during-drop sequences.
module tb_alien_fleet;

  logic       clk;
  logic       rst_n_a, frame_a, restart_a, hv_a;
  logic [1:0] hr_a;
  logic [2:0] hc_a;
  logic [9:0] dx_a, dy_a;
  logic       ack_a, isal_a, anim_a, clr_a, land_a;
  logic [1:0] arow_a;
  logic [2:0] acol_a;
  logic [9:0] fx_a, fy_a;
  logic [5:0] cnt_a;

  logic       rst_n_b, frame_b, restart_b, hv_b;
  logic [0:0] hr_b, hc_b, arow_b, acol_b, cnt_b;
  logic [9:0] dx_b, dy_b, fx_b, fy_b;
  logic       ack_b, isal_b, anim_b, clr_b, land_b;

  int errors = 0;
  int checks = 0;

  alien_fleet u_a (
    .Clk(clk), .Reset_n(rst_n_a), .frame_clk(frame_a), .restart(restart_a),
    .DrawX(dx_a), .DrawY(dy_a), .hit_valid(hv_a), .hit_row(hr_a), .hit_col(hc_a),
    .hit_ack(ack_a), .is_alien(isal_a), .alien_row(arow_a), .alien_col(acol_a),
    .anim_frame(anim_a), .fleet_x(fx_a), .fleet_y(fy_a), .alive_count(cnt_a),
    .fleet_cleared(clr_a), .fleet_landed(land_a)
  );

  alien_fleet #(.ROWS(1), .COLS(1), .X_START(4), .X_MAX(30), .Y_LAND(60)) u_b (
    .Clk(clk), .Reset_n(rst_n_b), .frame_clk(frame_b), .restart(restart_b),
    .DrawX(dx_b), .DrawY(dy_b), .hit_valid(hv_b), .hit_row(hr_b), .hit_col(hc_b),
    .hit_ack(ack_b), .is_alien(isal_b), .alien_row(arow_b), .alien_col(acol_b),
    .anim_frame(anim_b), .fleet_x(fx_b), .fleet_y(fy_b), .alive_count(cnt_b),
    .fleet_cleared(clr_b), .fleet_landed(land_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One frame strobe: three cycles high (step lands on the third edge), three low
  task automatic tick(input bit sel);
    if (sel) frame_b = 1'b1;
    else     frame_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    frame_a = 1'b0;
    frame_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic hit_a(input int r, input int c, input int exp_ack, input int exp_cnt);
    hv_a = 1'b1;
    hr_a = 2'(r);
    hc_a = 3'(c);
    @(posedge clk);
    #1;
    chk("hit_ack", int'(ack_a), exp_ack);
    hv_a = 1'b0;
    @(posedge clk);
    #1;
    chk("alive_count", int'(cnt_a), exp_cnt);
  endtask

  typedef struct {
    bit is_pix;
    int a;
    int b;
    int exp_f;
    int exp_v;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // pixel: a=DrawX b=DrawY exp_f=is_alien exp_v=row*16+col; hit: a=row b=col exp_f=ack exp_v=count
    vecs[0]  = '{1'b1, 165, 77, 1, 35};
    vecs[1]  = '{1'b1, 88,  40, 0, 0};
    vecs[2]  = '{1'b1, 87,  40, 1, 0};
    vecs[3]  = '{1'b1, 63,  40, 0, 0};
    vecs[4]  = '{1'b1, 311, 99, 1, 55};
    vecs[5]  = '{1'b1, 320, 40, 0, 0};
    vecs[6]  = '{1'b1, 64,  52, 0, 0};
    vecs[7]  = '{1'b0, 2,   3,  1, 31};
    vecs[8]  = '{1'b0, 2,   3,  0, 31};
    vecs[9]  = '{1'b1, 165, 77, 0, 0};
    vecs[10] = '{1'b0, 0,   0,  1, 30};
    vecs[11] = '{1'b1, 64,  40, 0, 0};
    vecs[12] = '{1'b1, 96,  40, 1, 1};

    rst_n_a = 0; frame_a = 0; restart_a = 0; hv_a = 0; hr_a = 0; hc_a = 0; dx_a = 0; dy_a = 0;
    rst_n_b = 0; frame_b = 0; restart_b = 0; hv_b = 0; hr_b = 0; hc_b = 0; dx_b = 0; dy_b = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n_a = 1;
    rst_n_b = 1;

    chk("rst_x", int'(fx_a), 64);
    chk("rst_y", int'(fy_a), 40);
    chk("rst_count", int'(cnt_a), 32);
    chk("rst_anim", int'(anim_a), 0);
    chk("rst_ack", int'(ack_a), 0);
    chk("rst_landed", int'(land_a), 0);
    chk("rst_cleared", int'(clr_a), 0);
    chk("rst_b_x", int'(fx_b), 4);

    foreach (vecs[i]) begin
      if (vecs[i].is_pix) begin
        dx_a = 10'(vecs[i].a);
        dy_a = 10'(vecs[i].b);
        #1;
        chk($sformatf("pix%0d_is_alien", i), int'(isal_a), vecs[i].exp_f);
        chk($sformatf("pix%0d_cell", i), int'(arow_a) * 16 + int'(acol_a), vecs[i].exp_v);
      end else begin
        hit_a(vecs[i].a, vecs[i].b, vecs[i].exp_f, vecs[i].exp_v);
      end
    end

    // Step period 9 with a full fleet
    rst_n_a = 0;
    @(posedge clk);
    #1;
    rst_n_a = 1;
    chk("rst2_count", int'(cnt_a), 32);
    for (int i = 1; i <= 8; i++) begin
      tick(0);
      chk($sformatf("tick%0d_x", i), int'(fx_a), 64);
    end
    tick(0);
    chk("tick9_x", int'(fx_a), 68);
    chk("tick9_anim", int'(anim_a), 1);

    // Only column 7 left: march right until the edge forces a drop
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 7; c++) hit_a(r, c, 1, 32 - (r * 7 + c + 1));
    for (int k = 0; k < 400 && fy_a == 10'd40; k++) tick(0);
    chk("drop_y", int'(fy_a), 48);
    chk("drop_x", int'(fx_a), 392);
    tick(0);
    chk("after_drop_x1", int'(fx_a), 392);
    tick(0);
    chk("after_drop_x2", int'(fx_a), 388);

    // Down to one alien: period becomes 1 after the next step
    hit_a(0, 7, 1, 3);
    hit_a(1, 7, 1, 2);
    hit_a(2, 7, 1, 1);
    tick(0);
    chk("fast_x0", int'(fx_a), 388);
    tick(0);
    chk("fast_x1", int'(fx_a), 384);
    tick(0);
    chk("fast_x2", int'(fx_a), 380);
    tick(0);
    chk("fast_x3", int'(fx_a), 376);
    hit_a(3, 7, 1, 0);
    chk("cleared", int'(clr_a), 1);
    tick(0);
    chk("cleared_no_move", int'(fx_a), 376);
    hit_a(3, 7, 0, 0);

    // Restart beats a simultaneous hit
    restart_a = 1; hv_a = 1; hr_a = 2'd1; hc_a = 3'd1;
    @(posedge clk);
    #1;
    restart_a = 0; hv_a = 0;
    chk("restart_ack", int'(ack_a), 0);
    chk("restart_count", int'(cnt_a), 32);
    chk("restart_x", int'(fx_a), 64);
    chk("restart_y", int'(fy_a), 40);
    chk("restart_cleared", int'(clr_a), 0);
    chk("restart_anim", int'(anim_a), 0);
    @(posedge clk);
    #1;
    chk("restart_hit_dropped", int'(cnt_a), 32);

    // Fleet b: drop, move left, drop again, land at y=56
    tick(1);
    chk("b_drop1_x", int'(fx_b), 4);
    chk("b_drop1_y", int'(fy_b), 48);
    chk("b_drop1_landed", int'(land_b), 0);
    tick(1);
    chk("b_left_x", int'(fx_b), 0);
    chk("b_left_y", int'(fy_b), 48);
    tick(1);
    chk("b_drop2_y", int'(fy_b), 56);
    chk("b_landed", int'(land_b), 1);
    tick(1);
    chk("b_halt_x", int'(fx_b), 0);
    chk("b_halt_y", int'(fy_b), 56);
    chk("b_landed_sticky", int'(land_b), 1);

    hv_b = 1;
    @(posedge clk);
    #1;
    chk("b_hit_landed_ack", int'(ack_b), 1);
    hv_b = 0;
    @(posedge clk);
    #1;
    chk("b_count", int'(cnt_b), 0);
    chk("b_cleared", int'(clr_b), 1);

    restart_b = 1;
    @(posedge clk);
    #1;
    restart_b = 0;
    chk("b_restart_landed", int'(land_b), 0);
    chk("b_restart_y", int'(fy_b), 40);
    chk("b_restart_x", int'(fx_b), 4);
    chk("b_restart_count", int'(cnt_b), 1);
    @(posedge clk);
    #1;
    chk("b_restart_landed2", int'(land_b), 0);

    // Reset asserted in the cycle the fleet sits in DROP
    frame_b = 1;
    for (int k = 0; k < 8 && anim_b == 1'b0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("b_drop_entry_anim", int'(anim_b), 1);
    rst_n_b = 0;
    frame_b = 0;
    @(posedge clk);
    #1;
    chk("b_rst_drop_y", int'(fy_b), 40);
    chk("b_rst_drop_x", int'(fx_b), 4);
    chk("b_rst_drop_anim", int'(anim_b), 0);
    chk("b_rst_drop_landed", int'(land_b), 0);
    chk("b_rst_drop_count", int'(cnt_b), 1);
    rst_n_b = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("b_post_rst_y", int'(fy_b), 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
